// File: rtl/uart_frame_core.sv
// uart_frame_core: parametrised full-duplex UART (5..8 data bits, optional parity,
// 1 or 2 stop bits, oversampled RX with glitch rejection).
// Optional build macro UART_RX_FIFO_EN: 4-entry RX FIFO with rx_pop / rx_ovr.
module uart_frame_core #(
  parameter int unsigned CLK_FREQ  = 1000000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned OVS       = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_perr,
  output logic                 rx_ferr
`ifdef UART_RX_FIFO_EN
  ,
  input  logic                 rx_pop,
  output logic                 rx_ovr
`endif
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD_RATE * OVS);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TW    = $clog2(OVS);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

  // Shared oversample tick: 1-clk pulse when the divider wraps
  logic [DIV_W-1:0] div_q;
  logic             tick;
  assign tick = (div_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_q <= '0;
    else      div_q <= tick ? '0 : div_q + DIV_W'(1);
  end

  // ---------------- TX ----------------
  tx_state_t            tx_st_q, tx_st_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d, tx_pend_q, tx_pend_d;
  logic [TW-1:0]        tx_tc_q, tx_tc_d;
  logic [2:0]           tx_bc_q, tx_bc_d;
  logic                 tx_sc_q, tx_sc_d;
  logic                 tx_q, tx_d, tx_ready_q, tx_ready_d, tx_done_q, tx_done_d;
  logic                 tx_bit_end;

  assign tx_bit_end = tick && (tx_tc_q == TW'(OVS - 1));
  assign tx         = tx_q;
  assign tx_ready   = tx_ready_q;
  assign tx_done    = tx_done_q;

  // TX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st_q <= TX_IDLE;  tx_sh_q <= '0;  tx_par_q <= 1'b0;  tx_pend_q <= 1'b0;
      tx_tc_q <= '0;       tx_bc_q <= '0;  tx_sc_q <= 1'b0;
      tx_q    <= 1'b1;     tx_ready_q <= 1'b1;  tx_done_q <= 1'b0;
    end else begin
      tx_st_q <= tx_st_d;  tx_sh_q <= tx_sh_d;  tx_par_q <= tx_par_d;  tx_pend_q <= tx_pend_d;
      tx_tc_q <= tx_tc_d;  tx_bc_q <= tx_bc_d;  tx_sc_q <= tx_sc_d;
      tx_q    <= tx_d;     tx_ready_q <= tx_ready_d;  tx_done_q <= tx_done_d;
    end
  end

  // TX next state: start waits for the next tick, then each bit spans OVS ticks
  always_comb begin
    tx_st_d = tx_st_q;  tx_sh_d = tx_sh_q;  tx_par_d = tx_par_q;  tx_pend_d = tx_pend_q;
    tx_tc_d = tx_tc_q;  tx_bc_d = tx_bc_q;  tx_sc_d = tx_sc_q;
    tx_d    = tx_q;     tx_ready_d = tx_ready_q;  tx_done_d = 1'b0;
    if (tick && !tx_bit_end) tx_tc_d = tx_tc_q + TW'(1);
    case (tx_st_q)
      TX_IDLE: begin
        tx_d       = 1'b1;
        tx_ready_d = 1'b1;
        if (tx_valid && tx_ready_q) begin
          tx_sh_d    = tx_data;
          tx_par_d   = (PARITY == 2) ? ~^tx_data : ^tx_data;
          tx_ready_d = 1'b0;
          tx_pend_d  = 1'b1;
          tx_st_d    = TX_START;
        end
      end
      TX_START: begin
        if (tick && tx_pend_q) begin
          tx_pend_d = 1'b0;
          tx_d      = 1'b0;
          tx_tc_d   = '0;
        end else if (tx_bit_end) begin
          tx_tc_d = '0;
          tx_bc_d = '0;
          tx_d    = tx_sh_q[0];
          tx_st_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_tc_d = '0;
          if (tx_bc_q == 3'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              tx_st_d = TX_PAR;
              tx_d    = tx_par_q;
            end else begin
              tx_st_d = TX_STOP;
              tx_d    = 1'b1;
              tx_sc_d = 1'b0;
            end
          end else begin
            tx_bc_d = tx_bc_q + 3'd1;
            tx_sh_d = tx_sh_q >> 1;
            tx_d    = tx_sh_q[1];
          end
        end
      end
      TX_PAR: begin
        if (tx_bit_end) begin
          tx_tc_d = '0;
          tx_sc_d = 1'b0;
          tx_d    = 1'b1;
          tx_st_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_tc_d = '0;
          if (tx_sc_q == 1'(STOP_BITS - 1)) begin
            tx_st_d    = TX_IDLE;
            tx_done_d  = 1'b1;
            tx_ready_d = 1'b1;
          end else begin
            tx_sc_d = 1'b1;
          end
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  // ---------------- RX ----------------
  logic                 rx_m_q, rx_s_q, rx_p_q;
  rx_state_t            rx_st_q, rx_st_d;
  logic [TW-1:0]        rx_tc_q, rx_tc_d;
  logic [2:0]           rx_bc_q, rx_bc_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_pe_q, rx_pe_d;
  logic                 rx_bit_end, rx_half_end, rx_par_exp;
  logic                 frm_done_c, frm_ferr_c;

  assign rx_bit_end  = tick && (rx_tc_q == TW'(OVS - 1));
  assign rx_half_end = tick && (rx_tc_q == TW'(OVS / 2 - 1));
  assign rx_par_exp  = (PARITY == 2) ? ~^rx_sh_q : ^rx_sh_q;

  // Synchroniser, previous-sample for edge detect, and RX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m_q <= 1'b1;  rx_s_q <= 1'b1;  rx_p_q <= 1'b1;
      rx_st_q <= RX_IDLE;  rx_tc_q <= '0;  rx_bc_q <= '0;  rx_sh_q <= '0;  rx_pe_q <= 1'b0;
    end else begin
      rx_m_q <= rx;  rx_s_q <= rx_m_q;  rx_p_q <= rx_s_q;
      rx_st_q <= rx_st_d;  rx_tc_q <= rx_tc_d;  rx_bc_q <= rx_bc_d;  rx_sh_q <= rx_sh_d;
      rx_pe_q <= rx_pe_d;
    end
  end

  // RX next state: a falling edge (never a held-low break) starts a frame
  always_comb begin
    rx_st_d = rx_st_q;  rx_tc_d = rx_tc_q;  rx_bc_d = rx_bc_q;  rx_sh_d = rx_sh_q;
    rx_pe_d = rx_pe_q;  frm_done_c = 1'b0;  frm_ferr_c = 1'b0;
    if (tick) rx_tc_d = rx_tc_q + TW'(1);
    case (rx_st_q)
      RX_IDLE: begin
        rx_tc_d = rx_tc_q;
        if (rx_p_q && !rx_s_q) begin
          rx_st_d = RX_START;
          rx_tc_d = '0;
          rx_pe_d = 1'b0;
        end
      end
      RX_START: begin
        if (rx_half_end) begin
          rx_tc_d = '0;
          rx_bc_d = '0;
          rx_st_d = rx_s_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_tc_d = '0;
          rx_sh_d = {rx_s_q, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bc_q == 3'(DATA_BITS - 1)) rx_st_d = (PARITY != 0) ? RX_PAR : RX_STOP;
          else                               rx_bc_d = rx_bc_q + 3'd1;
        end
      end
      RX_PAR: begin
        if (rx_bit_end) begin
          rx_tc_d = '0;
          rx_pe_d = rx_s_q ^ rx_par_exp;
          rx_st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_tc_d    = '0;
          frm_done_c = 1'b1;
          frm_ferr_c = ~rx_s_q;
          rx_st_d    = RX_IDLE;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  localparam int unsigned EW = DATA_BITS + 2;
  logic [EW-1:0] mem_q [4];
  logic [1:0]    wp_q, rp_q;
  logic [2:0]    cnt_q, cnt_d;
  logic          ovr_q, val_q, pop, store, full;

  assign full     = (cnt_q == 3'd4);
  assign pop      = rx_pop && (cnt_q != 3'd0);
  assign store    = frm_done_c && (!full || pop);
  assign rx_data  = mem_q[rp_q][DATA_BITS-1:0];
  assign rx_perr  = mem_q[rp_q][DATA_BITS];
  assign rx_ferr  = mem_q[rp_q][DATA_BITS+1];
  assign rx_valid = val_q;
  assign rx_ovr   = ovr_q;

  // FIFO occupancy after this clock's push/pop
  always_comb begin
    cnt_d = cnt_q;
    if (store && !pop)      cnt_d = cnt_q + 3'd1;
    else if (!store && pop) cnt_d = cnt_q - 3'd1;
  end

  // FIFO storage, pointers and sticky overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wp_q <= '0;  rp_q <= '0;  cnt_q <= '0;  ovr_q <= 1'b0;  val_q <= 1'b0;
    end else begin
      if (store) begin
        mem_q[wp_q] <= {frm_ferr_c, rx_pe_q, rx_sh_q};
        wp_q        <= wp_q + 2'd1;
      end
      if (pop) rp_q <= rp_q + 2'd1;
      cnt_q <= cnt_d;
      val_q <= (cnt_d != 3'd0);
      if (frm_done_c && !store)  ovr_q <= 1'b1;
      else if (pop && cnt_d == 3'd0) ovr_q <= 1'b0;
    end
  end
`else
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, rx_perr_q, rx_ferr_q;

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_perr  = rx_perr_q;
  assign rx_ferr  = rx_ferr_q;

  // Frame result registers, loaded together with the rx_valid pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_q <= '0;  rx_valid_q <= 1'b0;  rx_perr_q <= 1'b0;  rx_ferr_q <= 1'b0;
    end else begin
      rx_valid_q <= frm_done_c;
      if (frm_done_c) begin
        rx_data_q <= rx_sh_q;
        rx_perr_q <= rx_pe_q;
        rx_ferr_q <= frm_ferr_c;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_frame_core.sv
// Directed bench for uart_frame_core: dut_a uses defaults (8N1), dut_b uses even parity.
module tb_uart_frame_core;
  localparam int BT = 104;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut_a: defaults
  logic [7:0] tx_data_a = '0;
  logic       tx_valid_a = 1'b0, tx_ready_a, tx_a, tx_done_a;
  logic       rx_a = 1'b1;
  logic [7:0] rx_data_a;
  logic       rx_valid_a, rx_perr_a, rx_ferr_a;
`ifdef UART_RX_FIFO_EN
  logic       rx_pop_a = 1'b0, rx_ovr_a;
`endif

  uart_frame_core dut_a (
    .clk(clk), .rst(rst),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx(tx_a), .tx_done(tx_done_a),
    .rx(rx_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_perr(rx_perr_a), .rx_ferr(rx_ferr_a)
`ifdef UART_RX_FIFO_EN
    , .rx_pop(rx_pop_a), .rx_ovr(rx_ovr_a)
`endif
  );

  // dut_b: even parity, rx either looped from its own tx or driven by the bench
  logic [7:0] tx_data_b = '0;
  logic       tx_valid_b = 1'b0, tx_ready_b, tx_b, tx_done_b;
  logic       loop_b = 1'b0, rx_drv_b = 1'b1, rx_b;
  logic [7:0] rx_data_b;
  logic       rx_valid_b, rx_perr_b, rx_ferr_b;
  assign rx_b = loop_b ? tx_b : rx_drv_b;
`ifdef UART_RX_FIFO_EN
  logic       rx_pop_b, rx_ovr_b;
  assign rx_pop_b = rx_valid_b;
`endif

  uart_frame_core #(.PARITY(1)) dut_b (
    .clk(clk), .rst(rst),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx(tx_b), .tx_done(tx_done_b),
    .rx(rx_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_perr(rx_perr_b), .rx_ferr(rx_ferr_b)
`ifdef UART_RX_FIFO_EN
    , .rx_pop(rx_pop_b), .rx_ovr(rx_ovr_b)
`endif
  );

  // dut_b frame log {ferr, perr, data} and tx_done bookkeeping
  logic [9:0] q_b[$];
  int n_done_b = 0;
  int bad_rdy_b = 0;
  always @(negedge clk) begin
    if (rx_valid_b) q_b.push_back({rx_ferr_b, rx_perr_b, rx_data_b});
    if (tx_done_b) begin
      n_done_b <= n_done_b + 1;
      if (tx_ready_b !== 1'b1) bad_rdy_b <= bad_rdy_b + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_b(input logic [7:0] d, input logic p, input logic stop);
    rx_drv_b = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv_b = d[i];
      repeat (BT) @(negedge clk);
    end
    rx_drv_b = p;
    repeat (BT) @(negedge clk);
    rx_drv_b = stop;
    repeat (BT) @(negedge clk);
  endtask

`ifdef UART_RX_FIFO_EN
  task automatic send_a(input logic [7:0] d);
    rx_a = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_a = d[i];
      repeat (BT) @(negedge clk);
    end
    rx_a = 1'b1;
    repeat (BT) @(negedge clk);
  endtask
`endif

  task automatic offer_b(input logic [7:0] d, input string tag);
    int n = 0;
    tx_data_b  = d;
    tx_valid_b = 1'b1;
    while (tx_ready_b !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, tx_ready_b, 1);
    @(negedge clk);
    tx_valid_b = 1'b0;
  endtask

  task automatic wait_q_b(input int want, input string tag);
    int n = 0;
    while (q_b.size() < want && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, q_b.size(), want);
  endtask

  initial begin
    logic [9:0] exp_a5;
    int n, t_fall, dt;
    exp_a5 = {1'b1, 8'hA5, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_tx", tx_a, 1);
    chk("rst_tx_ready", tx_ready_a, 1);
    chk("rst_tx_done", tx_done_a, 0);
    chk("rst_rx_data", rx_data_b, 0);
    chk("rst_rx_valid", rx_valid_b, 0);
    chk("rst_rx_perr", rx_perr_b, 0);
    chk("rst_rx_ferr", rx_ferr_b, 0);
`ifdef UART_RX_FIFO_EN
    chk("rst_rx_ovr", rx_ovr_a, 0);
`endif
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 1: 8N1 transmit of A5 with per-bit centre sampling
    tx_data_a  = 8'hA5;
    tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    chk("t1_ready_low", tx_ready_a, 0);
    n = 0;
    while (tx_a !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t1_start_seen", tx_a, 0);
    t_fall = cyc;
    repeat (52) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t1_bit%0d", i), tx_a, exp_a5[i]);
      if (i < 9) repeat (BT) @(negedge clk);
    end
    n = 0;
    while (tx_done_a !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    dt = cyc - t_fall;
    chk("t1_done_seen", tx_done_a, 1);
    chk("t1_done_time", (dt >= 1039 && dt <= 1041), 1);
    chk("t1_ready_at_done", tx_ready_a, 1);
    @(negedge clk);
    chk("t1_done_pulse", tx_done_a, 0);

    // 2: even-parity loopback, back-to-back 3C then FF
    loop_b = 1'b1;
    offer_b(8'h3C, "t2_accept0");
    offer_b(8'hFF, "t2_accept1");
    wait_q_b(2, "t2_frames");
    repeat (BT) @(negedge clk);
    chk("t2_d0", q_b[0], {2'b00, 8'h3C});
    chk("t2_d1", q_b[1], {2'b00, 8'hFF});
    chk("t2_done_cnt", n_done_b, 2);
    chk("t2_ready_at_done", bad_rdy_b, 0);
    loop_b = 1'b0;
    repeat (BT) @(negedge clk);

    // 3: wrong parity bit on 3C
    send_b(8'h3C, 1'b1, 1'b1);
    wait_q_b(3, "t3_frames");
    chk("t3_perr", q_b[2], {2'b01, 8'h3C});

    // 4: framing error then line held low (break)
    send_b(8'h55, 1'b0, 1'b0);
    repeat (3 * BT) @(negedge clk);
    chk("t4_frames", q_b.size(), 4);
    chk("t4_ferr", q_b[3], {2'b10, 8'h55});
    rx_drv_b = 1'b1;
    repeat (2 * BT) @(negedge clk);
    chk("t4_no_rearm", q_b.size(), 4);

    // 5: short glitch rejected, then a good frame still decodes
    rx_drv_b = 1'b0;
    repeat (39) @(negedge clk);
    rx_drv_b = 1'b1;
    repeat (3 * BT) @(negedge clk);
    chk("t5_glitch", q_b.size(), 4);
    send_b(8'hA5, 1'b0, 1'b1);
    wait_q_b(5, "t5_frames");
    chk("t5_after_glitch", q_b[4], {2'b00, 8'hA5});

`ifdef UART_RX_FIFO_EN
    // 6: FIFO overrun and in-order drain
    begin
      logic [7:0] fexp [5];
      fexp = '{8'h11, 8'h22, 8'h3C, 8'h81, 8'hE7};
      for (int i = 0; i < 5; i++) send_a(fexp[i]);
      repeat (5) @(negedge clk);
      chk("t6_ovr_set", rx_ovr_a, 1);
      chk("t6_valid", rx_valid_a, 1);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t6_head%0d", i), rx_data_a, fexp[i]);
        chk($sformatf("t6_ovr_hold%0d", i), rx_ovr_a, 1);
        rx_pop_a = 1'b1;
        @(negedge clk);
        rx_pop_a = 1'b0;
      end
      chk("t6_ovr_clear", rx_ovr_a, 0);
      chk("t6_empty", rx_valid_a, 0);
    end
`endif

    // 7: reset asserted mid data bit aborts TX immediately
    tx_data_a  = 8'h00;
    tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    n = 0;
    while (tx_a !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (BT + 52) @(negedge clk);
    chk("t7_mid_data", tx_a, 0);
    #2 rst = 1'b0;
    #1;
    chk("t7_tx_high", tx_a, 1);
    chk("t7_ready_high", tx_ready_a, 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    chk("t7_stay_idle", tx_a, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
